alu_exec: RTL and testbench
===========================

# alu_exec

Registered execute-stage ALU that consumes the 4-bit `alu_ct` code from the ALU control decoder, along with operands `a`/`b` from the register file or immediate mux. It produces a registered result plus `zero`/`overflow` flags for the branch and write-back logic. Single-cycle operations complete in one clock. Multiply runs as an iterative shift-add sequence, and the core datapath stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `alu_ct`  in  4  operation code, sampled on accept.
- `a`  in  WIDTH  operand A, sampled on accept.
- `b`  in  WIDTH  operand B, sampled on accept.
- `start`  in  1  request; accepted when `start && !busy`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when `result` and flags are valid.
- `result`  out  WIDTH  registered result; holds until the next `done`.
- `zero`  out  1  result == 0; updates with `done`.
- `overflow`  out  1  signed overflow (ADD/SUB) or high-half-nonzero (MUL); 0 for other ops.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a-b)
  - 0111 SLT (signed; result 1 or 0)
  - 1100 NOR
  - 1000 MUL (unsigned; result = low WIDTH bits)
  - Any other code: result 0, overflow 0, `done` still pulses.
- Overflow rules:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from `a`.
  - MUL: upper WIDTH bits of the 2*WIDTH product are nonzero.
- FSM states:
  - IDLE: `busy`=0.
    - Accept of a non-MUL op: compute combinationally, register result/flags, pulse `done`, stay IDLE.
    - Accept of MUL: latch `a` into the multiplicand (zero-extended to 2*WIDTH), latch `b` into the multiplier, clear the 2*WIDTH accumulator and the counter, go to MUL.
  - MUL: `busy`=1, one step per cycle.
    - If multiplier LSB is 1, add the multiplicand to the accumulator.
    - Shift the multiplicand left 1 and the multiplier right 1; increment the counter.
    - After WIDTH steps go to FIN.
  - FIN: `busy`=1 for one cycle; register the low half to `result`, set `overflow` and `zero`, pulse `done`, return to IDLE.
- `start` while `busy`: ignored, and no state changes.
- Counter width is clog2(WIDTH)+1; the multiply never wraps early.
- Reset (asynchronous assert, any state, including mid-MUL):
  - State goes to IDLE.
  - `busy`, `done`, `result`, `zero`, `overflow` go to 0.
  - The in-flight multiply is discarded; no `done` is produced for it.
- Note: `zero` resets to 0, not 1, even though `result` is 0.

## Timing
- Non-MUL latency: accept at edge N produces `done`=1 and a valid result during cycle N+1. Back-to-back accepts every cycle are allowed, with one `done` per accept.
- MUL latency:
  - Accept at edge N.
  - `busy` is high from cycle N+1 through cycle N+WIDTH+1.
  - `done` pulses in cycle N+WIDTH+2, with `busy` low in that same cycle.
  - The earliest next accept is at edge N+WIDTH+2.
- `result` and flags are stable from `done` until the next `done` or reset.
- Reset deassertion is synchronised by the parent. The first accept is allowed on the first rising edge with `rst`=1.

## Test plan
- ADD: a=0x7FFFFFFF, b=1, code 0010 → next cycle `done`=1, result=0x80000000, overflow=1, zero=0.
- SUB: a=5, b=5, code 0110 → result 0, zero=1, overflow=0. SLT with a=0xFFFFFFFF, b=1 → result 1.
- Back-to-back: AND, OR, NOR on consecutive cycles with a=0xF0F0F0F0, b=0x0FF00FF0 → three consecutive `done` pulses with results 0x00F000F0, 0xFFF0FFF0, 0x000F000F.
- MUL: a=0x00010000, b=0x00010000 →
  - `busy` high for exactly 33 cycles.
  - `done` arrives 34 cycles after accept, with result 0 and overflow=1.
  - With a=123, b=456: result 56088, overflow=0.
- `start` during MUL with code 0010: ignored; exactly one `done` is produced, carrying the MUL result.
- Reset mid-MUL (assert `rst` at step 10):
  - Outputs are immediately 0 and `busy` is 0.
  - No `done` follows.
  - After release, ADD 2+3 gives result 5 one cycle after accept.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle logic/arithmetic ops register their result
// one clock after accept; MUL runs as a WIDTH-step shift-add sequence and
// holds busy until the final product is registered.
//
// state | meaning
// IDLE  | ready; accepts start, single-cycle ops complete here
// MUL   | one shift-add step per cycle, busy high
// FIN   | register low half of product and flags, pulse done
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_ct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;
    assign slt  = $signed(a) < $signed(b);

    // Single-cycle operation result and overflow flag
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ct)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE so it is ignored while busy
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && alu_ct == OP_MUL) state_nxt = MUL;
            MUL:     if (cnt == LAST_STEP) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand latch, shift-add steps and registered result/flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alu_ct == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                FIN: begin
                    result   <= acc[WIDTH-1:0];
                    zero     <= (acc[WIDTH-1:0] == '0);
                    overflow <= |acc[2*WIDTH-1:WIDTH];
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec with hand-computed expected values.
module tb_alu_exec;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [3:0]       alu_ct;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0]  bb_code [3];
    logic [31:0] bb_exp  [3];

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_ct   (alu_ct),
        .a        (a_i),
        .b        (b_i),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle op: accept on one edge, check done/result just after it
    task automatic op1(input string tag, input logic [3:0] code,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input logic exp_ovf, input logic exp_zero);
        @(negedge clk);
        start = 1'b1; alu_ct = code; a_i = av; b_i = bv;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_res"},  result, exp_res);
        chk({tag, "_ovf"},  {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    // Multiply with latency/busy accounting; optionally fires an ADD start mid-run
    task automatic run_mul(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_res, input logic exp_ovf, input logic intrude);
        int lat;
        int busy_n;
        int extra;
        @(negedge clk);
        start = 1'b1; alu_ct = 4'b1000; a_i = av; b_i = bv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; busy_n = 0; extra = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            if (intrude && lat == 5) begin
                start = 1'b1; alu_ct = 4'b0010; a_i = 32'd1; b_i = 32'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"},  lat, WIDTH + 2);
        chk({tag, "_busyn"}, busy_n, WIDTH + 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_res"},  result, exp_res);
        chk({tag, "_ovf"},  {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk({tag, "_extra_done"}, extra, 32'd0);
    endtask

    initial begin
        int stray;
        bb_code[0] = 4'b0000; bb_exp[0] = 32'h00F000F0;
        bb_code[1] = 4'b0001; bb_exp[1] = 32'hFFF0FFF0;
        bb_code[2] = 4'b1100; bb_exp[2] = 32'h000F000F;

        rst = 1'b1; start = 1'b0; alu_ct = 4'd0; a_i = '0; b_i = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res",  result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        @(negedge clk) rst = 1'b1;

        op1("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0);
        op1("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
        op1("sub_ovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0);
        op1("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        op1("slt_no", 4'b0111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1);
        op1("bad_code", 4'b0011, 32'h12345678, 32'h0000FFFF, 32'd0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; alu_ct = bb_code[i]; a_i = 32'hF0F0F0F0; b_i = 32'h0FF00FF0;
            @(posedge clk); #1;
            chk("b2b_done", {31'd0, done}, 32'd1);
            chk("b2b_res", result, bb_exp[i]);
            chk("b2b_ovf", {31'd0, overflow}, 32'd0);
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_done", {31'd0, done}, 32'd0);

        run_mul("mul_hi", 32'h00010000, 32'h00010000, 32'd0, 1'b1, 1'b0);
        run_mul("mul_small", 32'd123, 32'd456, 32'd56088, 1'b0, 1'b0);
        run_mul("mul_intr", 32'd1000, 32'd1000, 32'd1000000, 1'b0, 1'b1);

        op1("pre_rst", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; alu_ct = 4'b1000; a_i = 32'd77; b_i = 32'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_res",  result, 32'd0);
        chk("mid_rst_zero", {31'd0, zero}, 32'd0);
        chk("mid_rst_ovf",  {31'd0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        chk("post_rst_quiet", stray, 32'd0);
        op1("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
